// File: rtl/axis_lane_reverse.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_lane_reverse: registered AXI-Stream reorder stage (pass, lane/bit   |
// | reversal) with per-packet mode latch. Option: AXIS_LANE_REVERSE_ALIGN_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_lane_reverse #(
   parameter int LANES  = 32,
   parameter int LANE_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               mode,
   input  logic [LANES*LANE_W-1:0]  s_axis_tdata,
   input  logic [LANES-1:0]         s_axis_tkeep,
   input  logic                     s_axis_tlast,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   output logic [LANES*LANE_W-1:0]  m_axis_tdata,
   output logic [LANES-1:0]         m_axis_tkeep,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [31:0]              pkt_count
);

   localparam int DATA_W = LANES * LANE_W;

   localparam logic [1:0] c_mode_pass     = 2'd0;
   localparam logic [1:0] c_mode_lane_rev = 2'd1;
   localparam logic [1:0] c_mode_bit_rev  = 2'd2;
   localparam logic [1:0] c_mode_full_rev = 2'd3;

   logic              r_first;
   logic [1:0]        r_mode;
   logic [1:0]        w_mode;

   logic [DATA_W-1:0] w_lane_rev;
   logic [DATA_W-1:0] w_bit_rev;
   logic [DATA_W-1:0] w_full_rev;
   logic [LANES-1:0]  w_keep_rev;
   logic [DATA_W-1:0] w_data;
   logic [LANES-1:0]  w_keep;

   logic [DATA_W-1:0] r_m_tdata;
   logic [LANES-1:0]  r_m_tkeep;
   logic              r_m_tlast;
   logic              r_m_tvalid;
   logic [DATA_W-1:0] r_skid_data;
   logic [LANES-1:0]  r_skid_keep;
   logic              r_skid_last;
   logic              r_skid_valid;
   logic [31:0]       r_pkt_count;

   logic              w_in_xfer;
   logic              w_out_xfer;

   // The first beat of a packet uses the live mode; later beats use the latch.
   assign w_mode     = r_first ? mode : r_mode;
   assign w_in_xfer  = s_axis_tvalid & ~r_skid_valid;
   assign w_out_xfer = r_m_tvalid & m_axis_tready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_lane_rev[i*LANE_W +: LANE_W] = s_axis_tdata[(LANES-1-i)*LANE_W +: LANE_W];
      assign w_keep_rev[i]                  = s_axis_tkeep[LANES-1-i];
      for (genvar j = 0; j < LANE_W; j++) begin : g_bit
         assign w_bit_rev[i*LANE_W + j] = s_axis_tdata[i*LANE_W + LANE_W-1-j];
      end
   end

   for (genvar k = 0; k < DATA_W; k++) begin : g_full
      assign w_full_rev[k] = s_axis_tdata[DATA_W-1-k];
   end

`ifdef AXIS_LANE_REVERSE_ALIGN_EN
   localparam int CNT_W = $clog2(LANES + 1);

   logic [DATA_W-1:0] w_rev_data;
   logic [LANES-1:0]  w_rev_keep;
   logic [CNT_W-1:0]  w_ones;
   int                w_shift;

   always_comb begin
      w_ones = '0;
      for (int i = 0; i < LANES; i++) begin
         w_ones = w_ones + CNT_W'(s_axis_tkeep[i]);
      end
   end

   always_comb begin
      w_rev_data = s_axis_tdata;
      w_rev_keep = s_axis_tkeep;
      w_shift    = 0;
      case (w_mode)
         c_mode_lane_rev: begin w_rev_data = w_lane_rev; w_rev_keep = w_keep_rev; end
         c_mode_bit_rev:  begin w_rev_data = w_bit_rev;  w_rev_keep = s_axis_tkeep; end
         c_mode_full_rev: begin w_rev_data = w_full_rev; w_rev_keep = w_keep_rev; end
         default:         begin w_rev_data = s_axis_tdata; w_rev_keep = s_axis_tkeep; end
      endcase
      // Partial reversed beats: valid lanes sit at the top, pull them back to lane 0.
      if ((w_mode == c_mode_lane_rev || w_mode == c_mode_full_rev) && (s_axis_tkeep != '1)) begin
         w_shift = LANES - int'(w_ones);
         w_data  = w_rev_data >> (w_shift * LANE_W);
         w_keep  = w_rev_keep >> w_shift;
      end else begin
         w_data  = w_rev_data;
         w_keep  = w_rev_keep;
      end
   end
`else
   always_comb begin
      w_data = s_axis_tdata;
      w_keep = s_axis_tkeep;
      case (w_mode)
         c_mode_pass:     begin w_data = s_axis_tdata; w_keep = s_axis_tkeep; end
         c_mode_lane_rev: begin w_data = w_lane_rev;   w_keep = w_keep_rev;   end
         c_mode_bit_rev:  begin w_data = w_bit_rev;    w_keep = s_axis_tkeep; end
         default:         begin w_data = w_full_rev;   w_keep = w_keep_rev;   end
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_first      <= 1'b1;
         r_mode       <= 2'd0;
         r_m_tdata    <= '0;
         r_m_tkeep    <= '0;
         r_m_tlast    <= 1'b0;
         r_m_tvalid   <= 1'b0;
         r_skid_data  <= '0;
         r_skid_keep  <= '0;
         r_skid_last  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_pkt_count  <= '0;
      end else begin
         if (w_in_xfer) begin
            r_first <= s_axis_tlast;
            if (r_first) begin
               r_mode <= mode;
            end
         end

         if (!r_m_tvalid || m_axis_tready) begin
            // Skid is drained before any new input is accepted (tready is low then).
            if (r_skid_valid) begin
               r_m_tdata    <= r_skid_data;
               r_m_tkeep    <= r_skid_keep;
               r_m_tlast    <= r_skid_last;
               r_m_tvalid   <= 1'b1;
               r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
               r_m_tdata    <= w_data;
               r_m_tkeep    <= w_keep;
               r_m_tlast    <= s_axis_tlast;
               r_m_tvalid   <= 1'b1;
            end else begin
               r_m_tvalid   <= 1'b0;
            end
         end else if (w_in_xfer) begin
            r_skid_data  <= w_data;
            r_skid_keep  <= w_keep;
            r_skid_last  <= s_axis_tlast;
            r_skid_valid <= 1'b1;
         end

         if (w_out_xfer && r_m_tlast) begin
            r_pkt_count <= r_pkt_count + 32'd1;
         end
      end
   end

   assign s_axis_tready = ~r_skid_valid;
   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tvalid = r_m_tvalid;
   assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_lane_reverse.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_lane_reverse: vector table, corner sequences and random traffic  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axis_lane_reverse;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;
   localparam int DATA_W = LANES * LANE_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic [DATA_W-1:0] s_axis_tdata = '0;
   logic [LANES-1:0]  s_axis_tkeep = '0;
   logic              s_axis_tlast = 1'b0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic [LANES-1:0]  m_axis_tkeep;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b1;
   logic [31:0]       pkt_count;

   axis_lane_reverse #(.LANES(LANES), .LANE_W(LANE_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode          (mode),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .pkt_count     (pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] data;
      logic [3:0]  keep;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   vec_t  vecs[8];
   beat_t expq[$];

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;
   int out_beats = 0;
   int cur_low = 0;
   int max_low = 0;
   int low_cycles = 0;
   int cyc = 0;
   int rdy_sel = 0;
   int pat_idx = 0;
   logic [7:0] pat = 8'hD9;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if ((b >> i) & 8'h01) r = r | (8'h80 >> i);
      end
      return r;
   endfunction

   // Reference: byte array view; full reversal = lane reversal of bit-reversed lanes.
   task automatic model(input logic [1:0] md, input logic [31:0] d, input logic [3:0] k,
                        output logic [31:0] od, output logic [3:0] ok);
      logic [7:0] b[4];
      logic [3:0] krev = 4'h0;
      int n;
      for (int i = 0; i < 4; i++) b[i] = 8'(d >> (8 * i));
      for (int i = 0; i < 4; i++) if ((k >> (3 - i)) & 4'h1) krev = krev | (4'h1 << i);
      od = 32'h0;
      ok = k;
      for (int i = 0; i < 4; i++) begin
         case (md)
            2'd0: od = d;
            2'd1: od = od | (32'(b[3 - i]) << (8 * i));
            2'd2: od = od | (32'(rev8(b[i])) << (8 * i));
            default: od = od | (32'(rev8(b[3 - i])) << (8 * i));
         endcase
      end
      if (md == 2'd1 || md == 2'd3) ok = krev;
`ifdef AXIS_LANE_REVERSE_ALIGN_EN
      if ((md == 2'd1 || md == 2'd3) && k != 4'hF) begin
         n  = $countones(k);
         od = od >> (8 * (4 - n));
         ok = 4'((1 << n) - 1);
      end
`endif
   endtask

   always @(posedge clk) cyc++;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_sel)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: begin m_axis_tready = pat[pat_idx % 8]; pat_idx++; end
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (!s_axis_tready) begin
            cur_low++;
            low_cycles++;
            if (cur_low > max_low) max_low = cur_low;
         end else begin
            cur_low = 0;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            out_beats++;
            check("pkt_count", pkt_count, model_cnt);
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=0x%08h required=none", m_axis_tdata);
            end else begin
               e = expq.pop_front();
               check("out_data", m_axis_tdata, e.d);
               check("out_keep", 32'(m_axis_tkeep), 32'(e.k));
               check("out_last", 32'(m_axis_tlast), 32'(e.l));
            end
            if (m_axis_tlast) model_cnt++;
         end
      end
   end

   task automatic send(input logic [1:0] md, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic [31:0] ed, input logic [3:0] ek);
      bit acc = 1'b0;
      int n = 0;
      mode = md; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = s_axis_tready;
         if (acc) expq.push_back('{ed, ek, l});
         @(posedge clk);
         #1;
         n++;
      end
      s_axis_tvalid = 1'b0;
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (expq.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(expq.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, ed;
      logic [3:0]  k, ek;
      logic [1:0]  md, pmode;
      bit          first;
      int          base, lc0, t0, len;

      vecs[0] = '{2'd1, 32'h11223344, 4'hF, 32'h44332211, 4'hF};
`ifdef AXIS_LANE_REVERSE_ALIGN_EN
      vecs[1] = '{2'd3, 32'h00000001, 4'h1, 32'h00000080, 4'h1};
      vecs[5] = '{2'd1, 32'hAABBCCDD, 4'h3, 32'h0000DDCC, 4'h3};
`else
      vecs[1] = '{2'd3, 32'h00000001, 4'h1, 32'h80000000, 4'h8};
      vecs[5] = '{2'd1, 32'hAABBCCDD, 4'h3, 32'hDDCCBBAA, 4'hC};
`endif
      vecs[2] = '{2'd0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 4'hF};
      vecs[3] = '{2'd2, 32'h01020304, 4'hF, 32'h8040C020, 4'hF};
      vecs[4] = '{2'd3, 32'h12345678, 4'hF, 32'h1E6A2C48, 4'hF};
      vecs[6] = '{2'd2, 32'h0F0000F0, 4'h7, 32'hF000000F, 4'h7};
      vecs[7] = '{2'd0, 32'h00000055, 4'h1, 32'h00000055, 4'h1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tdata", m_axis_tdata, 32'd0);
      check("rst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
      check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_pkt_count", pkt_count, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_s_tready", 32'(s_axis_tready), 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].mode, vecs[i].data, vecs[i].keep, 1'b1, vecs[i].exp_data, vecs[i].exp_keep);
         @(negedge clk);
         check("latency_valid", 32'(m_axis_tvalid), 32'd1);
         wait_drain();
         check("table_pkt_count", pkt_count, 32'(i + 1));
      end

      // Mode sampled on beat 0 only; later mode changes are ignored.
      send(2'd2, 32'h01010101, 4'hF, 1'b0, 32'h80808080, 4'hF);
      send(2'd1, 32'h01010101, 4'hF, 1'b0, 32'h80808080, 4'hF);
      send(2'd1, 32'h01010101, 4'hF, 1'b1, 32'h80808080, 4'hF);
      wait_drain();

      pat_idx = 0;
      rdy_sel = 2;
      max_low = 0;
      cur_low = 0;
      base = out_beats;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         send(2'd0, d, 4'hF, 1'(i == 7), d, 4'hF);
      end
      wait_drain();
      check("toggle_beats", 32'(out_beats - base), 32'd8);
      check("toggle_low_run_le2", 32'(max_low <= 2), 32'd1);

      rdy_sel = 0;
      repeat (2) @(posedge clk);
      #1;
      base = out_beats;
      lc0 = low_cycles;
      t0 = cyc;
      for (int i = 0; i < 100; i++) begin
         d = $urandom;
         model(2'd1, d, 4'hF, ed, ek);
         send(2'd1, d, 4'hF, 1'(i == 99), ed, ek);
      end
      check("stream_cycles", 32'(cyc - t0), 32'd100);
      wait_drain();
      check("stream_beats", 32'(out_beats - base), 32'd100);
      check("stream_tready_low", 32'(low_cycles - lc0), 32'd0);

      rdy_sel = 1;
      first = 1'b1;
      pmode = 2'd0;
      for (int p = 0; p < 80; p++) begin
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            md = 2'($urandom_range(0, 3));
            if (first) pmode = md;
            first = (b == len - 1);
            d = $urandom;
            k = (b == len - 1) ? 4'(((1 << $urandom_range(1, 4)) - 1)) : 4'hF;
            model(pmode, d, k, ed, ek);
            send(md, d, k, 1'(b == len - 1), ed, ek);
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_drain();
      rdy_sel = 0;
      repeat (2) @(posedge clk);
      #1;

      rdy_sel = 3;
      repeat (2) @(posedge clk);
      #1;
      model(2'd1, 32'hA1A2A3A4, 4'hF, ed, ek);
      send(2'd1, 32'hA1A2A3A4, 4'hF, 1'b0, ed, ek);
      send(2'd1, 32'hB1B2B3B4, 4'hF, 1'b0, 32'hB4B3B2B1, 4'hF);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("midrst_pkt_count", pkt_count, 32'd0);
      expq.delete();
      model_cnt = 0;
      rdy_sel = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(2'd0, 32'hCAFEF00D, 4'hF, 1'b1, 32'hCAFEF00D, 4'hF);
      wait_drain();
      check("post_rst_pkt_count", pkt_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axis_lane_reverse.md
Name: axis_lane_reverse

Overview:
- Registered AXI-Stream stage that reorders tdata/tkeep per packet: pass-through, lane (byte) reversal, bit reversal within each lane, or full bit reversal.
- Generalises the combinational tkeep bit-swap into a parametrised, handshaked, full-throughput pipeline stage.
- Sits between the packet parser and the DMA/width converters, where endianness or tkeep orientation must flip per flow.

Parameters:
LANES, 32, number of lanes; tkeep width.
LANE_W, 8, bits per lane; tdata width = LANES*LANE_W (derived localparam DATA_W).

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
mode  input  2  reorder mode, sampled on first beat of each packet: 0 pass, 1 lane reverse, 2 bit-in-lane reverse, 3 full bit reverse.
s_axis_tdata  input  DATA_W  input data.
s_axis_tkeep  input  LANES  input lane enables.
s_axis_tlast  input  1  input end of packet.
s_axis_tvalid  input  1  input valid.
s_axis_tready  output  1  input ready; registered.
m_axis_tdata  output  DATA_W  output data; registered.
m_axis_tkeep  output  LANES  output lane enables; registered.
m_axis_tlast  output  1  output end of packet; registered.
m_axis_tvalid  output  1  output valid; registered.
m_axis_tready  input  1  output ready.
pkt_count  output  32  packets completed at output; wraps.

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, s_axis_tready=1 on first cycle after release, pkt_count=0, first-beat flag=1, latched mode=0.
- Input transfer on s_tvalid&s_tready; output transfer on m_tvalid&m_tready. No combinational path from m_axis_tready to s_axis_tready.
- Buffering: output register plus one skid register (2 entries). s_tready = skid empty. Full throughput (1 beat/cycle) under continuous m_tready=1; latency 1 cycle from input transfer to m_tvalid.
- Mode latching: on an input transfer with first-beat flag=1, the current mode is used for that beat and latched for the rest of the packet. The flag clears on transfer and sets on transfer with tlast=1. Mode changes mid-packet are ignored. Single-beat packet (tlast on first beat) uses the live mode.
- Mode 0: data and tkeep unchanged.
- Mode 1: output lane i = input lane LANES-1-i; tkeep bit i = input tkeep bit LANES-1-i.
- Mode 2: within each lane, bit j = bit LANE_W-1-j; tkeep unchanged.
- Mode 3: tdata bit k = input bit DATA_W-1-k; tkeep reversed as mode 1.
- tlast passes through unchanged. Reorder is combinational before the capture register.
- pkt_count increments by 1 on each output transfer with m_tlast=1 and wraps 0xFFFFFFFF->0.
- Backpressure: m_tready low with output full captures the next beat into skid; s_tready drops the following cycle. When m_tready returns, skid drains to output before new input is accepted. No beat is dropped or duplicated.
- Simultaneous input and output transfer with skid empty: output register reloads directly.
- Reset mid-packet: all buffered beats are discarded, the first-beat flag is set, and the next accepted beat samples mode fresh.

Optional Feature:
- Macro AXIS_LANE_REVERSE_ALIGN_EN.
- Defined: on beats in modes 1/3 whose tkeep is not all-ones (contiguous low lanes 0..k-1 valid), the reversed result is shifted down by LANES-k lanes. Valid data then occupies lanes 0..k-1 and tkeep = k low ones. Vacated high lanes are zero.
- Undefined: no shift; reversed partial beats keep valid lanes at the top (LANES-k..LANES-1).
- Modes 0/2 are unaffected either way. Non-contiguous tkeep is not supported with the macro defined.

Test Plan:
- LANES=4, LANE_W=8, mode=1, single beat tdata=0x11223344, tkeep=0xF, tlast=1 -> one cycle later m_tdata=0x44332211, tkeep=0xF, tlast=1, pkt_count=1.
- mode=3, tdata=0x00000001, tkeep=0x1, tlast=1 -> m_tdata=0x80000000, tkeep=0x8; with ALIGN_EN, m_tdata=0x00000080, tkeep=0x1.
- 3-beat packet, mode=2 on beat 0 then mode=1 on beats 1-2, lane value 0x01 -> all beats output lanes 0x80, tkeep unchanged.
- Stream 8 beats with m_tready toggling 1,0,0,1,1,0,1,1 -> all 8 beats emitted in order, none duplicated, s_tready never 0 for more than 2 consecutive cycles.
- Continuous 100-beat stream with m_tready=1 -> 100 consecutive output beats, s_tready constantly 1.
- Assert rst_n low after beat 2 of a 4-beat mode-1 packet, then send a mode-0 packet -> m_tvalid=0 during reset; new packet passes unchanged; pkt_count restarts from 0.
